// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I constants for the decode/operand stage.
//   - ALU op encodings (4 bits), matching the downstream ALU.
//   - Base opcode values (instr[6:0]).
//   - Instruction class encodings carried alongside the operands.
package rv32_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] CLS_ALU    = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_STORE  = 3'd2;
  localparam logic [2:0] CLS_BRANCH = 3'd3;
  localparam logic [2:0] CLS_JUMP   = 3'd4;
  localparam logic [2:0] CLS_UPPER  = 3'd5;

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate extraction.
// Ports:
//   i_instr  - 32-bit instruction word
//   o_imm_i  - sign-extended I-type immediate
//   o_imm_s  - sign-extended S-type immediate
//   o_imm_u  - U-type immediate (upper 20 bits, low 12 zero)
module imm_gen (
  input  logic [31:0] i_instr,
  output logic [31:0] o_imm_i,
  output logic [31:0] o_imm_s,
  output logic [31:0] o_imm_u
);

  assign o_imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign o_imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign o_imm_u = {i_instr[31:12], 12'h000};

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: RV32I decode/operand stage feeding the ALU.
// Decodes ALU op and A/B operands from the incoming instruction and holds
// them in a single valid/ready slot together with writeback control.
// Ports:
//   i_clk, i_rst_n            - clock, async active-low reset
//   i_valid / o_ready         - upstream handshake (o_ready = ~o_valid | i_ready)
//   i_instr, i_pc             - instruction word and its address
//   i_rs1_data, i_rs2_data    - register-file read data
//   i_flush                   - kill held and incoming instruction
//   o_valid / i_ready         - downstream handshake
//   o_A, o_B, o_op            - ALU operands and op
//   o_rd, o_wb_en             - destination register and writeback enable
//   o_pc, o_rs2_data          - PC and raw rs2 of the held instruction
//   o_funct3, o_cls           - funct3 and instruction class
//   o_illegal                 - only with ID_ILLEGAL_CHK_EN defined
// Build option: ID_ILLEGAL_CHK_EN adds illegal-instruction flagging.
module id_ex_stage
  import rv32_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_A,
  output logic [XLEN-1:0] o_B,
  output logic [3:0]      o_op,
  output logic [4:0]      o_rd,
  output logic            o_wb_en,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs2_data,
  output logic [2:0]      o_funct3,
`ifdef ID_ILLEGAL_CHK_EN
  output logic            o_illegal,
`endif
  output logic [2:0]      o_cls
);

  logic [XLEN-1:0] imm_i, imm_s, imm_u;

  imm_gen u_imm_gen (
    .i_instr (i_instr),
    .o_imm_i (imm_i),
    .o_imm_s (imm_s),
    .o_imm_u (imm_u)
  );

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = i_instr[6:0];
  assign funct3 = i_instr[14:12];
  assign funct7 = i_instr[31:25];
  assign rd     = i_instr[11:7];

  logic [XLEN-1:0] a_d, b_d;
  logic [3:0]      op_d;
  logic [2:0]      cls_d;
  logic            writes;
  logic            ill_d;
  logic            wb_d;

  always_comb begin
    a_d    = '0;
    b_d    = '0;
    op_d   = ALU_ADD;
    cls_d  = CLS_ALU;
    writes = 1'b0;
    ill_d  = 1'b0;
    case (opcode)
      OPC_OP: begin
        a_d    = i_rs1_data;
        b_d    = i_rs2_data;
        writes = 1'b1;
        case (funct3)
          3'b000: op_d = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: begin
            op_d = ALU_SLL;
            b_d  = {{(XLEN-5){1'b0}}, i_rs2_data[4:0]};
          end
          3'b010: op_d = ALU_SLT;
          3'b011: op_d = ALU_SLTU;
          3'b100: op_d = ALU_XOR;
          3'b101: begin
            op_d = funct7[5] ? ALU_SRA : ALU_SRL;
            b_d  = {{(XLEN-5){1'b0}}, i_rs2_data[4:0]};
          end
          3'b110: op_d = ALU_OR;
          default: op_d = ALU_AND;
        endcase
        if (funct7 != 7'b0000000 && funct7 != 7'b0100000)
          ill_d = 1'b1;
        else if (funct7[5] && funct3 != 3'b000 && funct3 != 3'b101)
          ill_d = 1'b1;
      end
      OPC_OP_IMM: begin
        a_d    = i_rs1_data;
        b_d    = imm_i;
        writes = 1'b1;
        case (funct3)
          3'b000: op_d = ALU_ADD;
          3'b001: begin
            op_d = ALU_SLL;
            b_d  = {{(XLEN-5){1'b0}}, i_instr[24:20]};
          end
          3'b010: op_d = ALU_SLT;
          3'b011: op_d = ALU_SLTU;
          3'b100: op_d = ALU_XOR;
          3'b101: begin
            op_d = funct7[5] ? ALU_SRA : ALU_SRL;
            b_d  = {{(XLEN-5){1'b0}}, i_instr[24:20]};
          end
          3'b110: op_d = ALU_OR;
          default: op_d = ALU_AND;
        endcase
        // funct7 only encodes anything for the shift-immediate forms
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          ill_d = 1'b1;
        else if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          ill_d = 1'b1;
      end
      OPC_LOAD: begin
        a_d    = i_rs1_data;
        b_d    = imm_i;
        cls_d  = CLS_LOAD;
        writes = 1'b1;
      end
      OPC_STORE: begin
        a_d   = i_rs1_data;
        b_d   = imm_s;
        cls_d = CLS_STORE;
      end
      OPC_BRANCH: begin
        a_d   = i_rs1_data;
        b_d   = i_rs2_data;
        cls_d = CLS_BRANCH;
        case (funct3[2:1])
          2'b10:   op_d = ALU_SLT;
          2'b11:   op_d = ALU_SLTU;
          default: op_d = ALU_SUB;
        endcase
      end
      OPC_JAL, OPC_JALR: begin
        // ALU computes the link value pc+4; target is formed elsewhere
        a_d    = i_pc;
        b_d    = 32'd4;
        cls_d  = CLS_JUMP;
        writes = 1'b1;
      end
      OPC_LUI: begin
        b_d    = imm_u;
        cls_d  = CLS_UPPER;
        writes = 1'b1;
      end
      OPC_AUIPC: begin
        a_d    = i_pc;
        b_d    = imm_u;
        cls_d  = CLS_UPPER;
        writes = 1'b1;
      end
      default: ill_d = 1'b1;
    endcase
  end

`ifdef ID_ILLEGAL_CHK_EN
  assign wb_d = writes & (rd != 5'd0) & ~ill_d;
`else
  logic unused_ill;
  assign unused_ill = ill_d;
  assign wb_d = writes & (rd != 5'd0);
`endif

  logic            valid_q;
  logic [XLEN-1:0] a_q, b_q, pc_q, rs2_q;
  logic [3:0]      op_q;
  logic [4:0]      rd_q;
  logic            wb_q;
  logic [2:0]      funct3_q, cls_q;
  logic            ill_q;
  logic            load;

  assign o_ready = ~valid_q | i_ready;
  assign load    = i_valid & o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      pc_q     <= RESET_PC_TAG;
      rs2_q    <= '0;
      funct3_q <= '0;
      cls_q    <= CLS_ALU;
      ill_q    <= 1'b0;
    end else begin
      if (i_flush)
        valid_q <= 1'b0;
      else if (load)
        valid_q <= 1'b1;
      else if (i_ready)
        valid_q <= 1'b0;

      if (load) begin
        a_q      <= a_d;
        b_q      <= b_d;
        op_q     <= op_d;
        rd_q     <= rd;
        wb_q     <= wb_d;
        pc_q     <= i_pc;
        rs2_q    <= i_rs2_data;
        funct3_q <= funct3;
        cls_q    <= cls_d;
        ill_q    <= ill_d;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_A        = a_q;
  assign o_B        = b_q;
  assign o_op       = op_q;
  assign o_rd       = rd_q;
  assign o_wb_en    = wb_q;
  assign o_pc       = pc_q;
  assign o_rs2_data = rs2_q;
  assign o_funct3   = funct3_q;
  assign o_cls      = cls_q;

`ifdef ID_ILLEGAL_CHK_EN
  assign o_illegal = ill_q;
`else
  logic unused_ill_q;
  assign unused_ill_q = ill_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam logic [31:0] PC_TAG = 32'hDEAD_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready, i_flush;
  logic        o_ready, o_valid, o_wb_en;
  logic [31:0] i_instr, i_pc, i_rs1, i_rs2;
  logic [31:0] o_A, o_B, o_pc, o_rs2_data;
  logic [3:0]  o_op;
  logic [4:0]  o_rd;
  logic [2:0]  o_funct3, o_cls;
`ifdef ID_ILLEGAL_CHK_EN
  logic        o_illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .RESET_PC_TAG(PC_TAG)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1_data (i_rs1),
    .i_rs2_data (i_rs2),
    .i_flush    (i_flush),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_A        (o_A),
    .o_B        (o_B),
    .o_op       (o_op),
    .o_rd       (o_rd),
    .o_wb_en    (o_wb_en),
    .o_pc       (o_pc),
    .o_rs2_data (o_rs2_data),
    .o_funct3   (o_funct3),
`ifdef ID_ILLEGAL_CHK_EN
    .o_illegal  (o_illegal),
`endif
    .o_cls      (o_cls)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one instruction for one cycle with downstream ready, then idle
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    i_instr = instr;
    i_pc    = pc;
    i_rs1   = rs1;
    i_rs2   = rs2;
    i_valid = 1'b1;
    i_ready = 1'b1;
    step();
    i_valid = 1'b0;
    check_eq("valid_after_load", {31'b0, o_valid}, 32'd1);
  endtask

  initial begin
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_flush = 1'b0;
    i_instr = '0;
    i_pc    = '0;
    i_rs1   = '0;
    i_rs2   = '0;
    step();
    step();
    check_eq("rst_valid", {31'b0, o_valid}, 32'd0);
    check_eq("rst_pc", o_pc, PC_TAG);
    check_eq("rst_A", o_A, 32'd0);
    check_eq("rst_ready", {31'b0, o_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // add x3,x1,x2
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    check_eq("add_A", o_A, 32'd5);
    check_eq("add_B", o_B, 32'd7);
    check_eq("add_op", {28'b0, o_op}, 32'd0);
    check_eq("add_rd", {27'b0, o_rd}, 32'd3);
    check_eq("add_wb", {31'b0, o_wb_en}, 32'd1);
`ifdef ID_ILLEGAL_CHK_EN
    check_eq("add_ill", {31'b0, o_illegal}, 32'd0);
`endif

    // sub x3,x1,x2
    issue(32'h402081B3, 32'h0, 32'd9, 32'd2);
    check_eq("sub_op", {28'b0, o_op}, 32'd1);

    // srai x5,x6,3
    issue(32'h40335293, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("srai_op", {28'b0, o_op}, 32'd7);
    check_eq("srai_B", o_B, 32'd3);
    check_eq("srai_A", o_A, 32'h8000_0000);
    check_eq("srai_rd", {27'b0, o_rd}, 32'd5);

    // sll x1,x2,x3 with rs2 = 0x21 -> shift amount masked to 1
    issue(32'h003110B3, 32'h0, 32'h1, 32'h21);
    check_eq("sll_op", {28'b0, o_op}, 32'd5);
    check_eq("sll_B", o_B, 32'd1);

    // lui x1,0x12345
    issue(32'h123450B7, 32'h40, 32'h55, 32'h66);
    check_eq("lui_A", o_A, 32'd0);
    check_eq("lui_B", o_B, 32'h1234_5000);
    check_eq("lui_cls", {29'b0, o_cls}, 32'd5);
    check_eq("lui_wb", {31'b0, o_wb_en}, 32'd1);

    // auipc x2,1 at pc 0x100
    issue(32'h00001117, 32'h100, 32'h55, 32'h66);
    check_eq("auipc_A", o_A, 32'h100);
    check_eq("auipc_B", o_B, 32'h1000);
    check_eq("auipc_pc", o_pc, 32'h100);

    // beq x1,x2,8
    issue(32'h00208463, 32'h80, 32'd1, 32'd1);
    check_eq("beq_op", {28'b0, o_op}, 32'd1);
    check_eq("beq_wb", {31'b0, o_wb_en}, 32'd0);
    check_eq("beq_cls", {29'b0, o_cls}, 32'd3);

    // unknown opcode 7F with rd = 3
    issue(32'h000001FF, 32'h0, 32'h11, 32'h22);
    check_eq("unk_wb", {31'b0, o_wb_en}, 32'd0);
    check_eq("unk_A", o_A, 32'd0);
    check_eq("unk_B", o_B, 32'd0);
    check_eq("unk_cls", {29'b0, o_cls}, 32'd0);
`ifdef ID_ILLEGAL_CHK_EN
    check_eq("unk_ill", {31'b0, o_illegal}, 32'd1);
`endif

    // sw x2,4(x1)
    issue(32'h0020A223, 32'h0, 32'h1000, 32'hCAFE_F00D);
    check_eq("sw_B", o_B, 32'd4);
    check_eq("sw_cls", {29'b0, o_cls}, 32'd2);
    check_eq("sw_wb", {31'b0, o_wb_en}, 32'd0);
    check_eq("sw_rs2", o_rs2_data, 32'hCAFE_F00D);
    check_eq("sw_f3", {29'b0, o_funct3}, 32'd2);

    // addi x1,x0,-1
    issue(32'hFFF00093, 32'h0, 32'd0, 32'd0);
    check_eq("addi_B", o_B, 32'hFFFF_FFFF);
    check_eq("addi_op", {28'b0, o_op}, 32'd0);

    // add x0,x1,x2 -> no writeback
    issue(32'h00208033, 32'h0, 32'd1, 32'd2);
    check_eq("x0_wb", {31'b0, o_wb_en}, 32'd0);

    // jal x1,8 at pc 0x200
    issue(32'h008000EF, 32'h200, 32'h0, 32'h0);
    check_eq("jal_A", o_A, 32'h200);
    check_eq("jal_B", o_B, 32'd4);
    check_eq("jal_cls", {29'b0, o_cls}, 32'd4);
    check_eq("jal_wb", {31'b0, o_wb_en}, 32'd1);

    // drain: nothing offered, downstream ready
    step();
    check_eq("drain_valid", {31'b0, o_valid}, 32'd0);

    // hold: load add x3 with downstream stalled
    i_instr = 32'h002081B3; i_rs1 = 32'd5; i_rs2 = 32'd7;
    i_valid = 1'b1; i_ready = 1'b0;
    step();
    check_eq("hold_load_valid", {31'b0, o_valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      i_instr = 32'h123450B7 + k;
      i_rs1   = 32'h100 + k;
      step();
      check_eq("hold_valid", {31'b0, o_valid}, 32'd1);
      check_eq("hold_ready", {31'b0, o_ready}, 32'd0);
      check_eq("hold_rd", {27'b0, o_rd}, 32'd3);
      check_eq("hold_A", o_A, 32'd5);
    end
    i_instr = 32'h123450B7;
    i_ready = 1'b1;
    step();
    check_eq("b2b_valid", {31'b0, o_valid}, 32'd1);
    check_eq("b2b_rd", {27'b0, o_rd}, 32'd1);
    check_eq("b2b_cls", {29'b0, o_cls}, 32'd5);

    // flush beats a simultaneous load
    i_flush = 1'b1;
    i_instr = 32'h002081B3;
    step();
    i_flush = 1'b0;
    check_eq("flush_valid", {31'b0, o_valid}, 32'd0);

    // async reset while stalled
    i_ready = 1'b0;
    i_pc    = 32'h300;
    step();
    check_eq("stall_valid", {31'b0, o_valid}, 32'd1);
    i_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", {31'b0, o_valid}, 32'd0);
    check_eq("arst_pc", o_pc, PC_TAG);
    check_eq("arst_A", o_A, 32'd0);
    check_eq("arst_rd", {27'b0, o_rd}, 32'd0);
    check_eq("arst_wb", {31'b0, o_wb_en}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/operand stage directly upstream of the RV32I ALU.
- Accepts a fetched instruction, its PC and register-file read data; decodes the ALU operation and the A/B operand selection.
- Registers the results into a single valid/ready pipeline slot that feeds the ALU inputs and carries writeback control forward.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, value driven on o_pc during reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  upstream instruction valid.
- o_ready  out  1  stage can accept; equals ~o_valid | i_ready (combinational).
- i_instr  in  32  instruction word.
- i_pc  in  32  instruction address.
- i_rs1_data  in  32  register-file read data for instr[19:15].
- i_rs2_data  in  32  register-file read data for instr[24:20].
- i_flush  in  1  kill the held and the incoming instruction (branch redirect).
- o_valid  out  1  slot holds a valid decoded instruction.
- i_ready  in  1  downstream (ALU/EX) accepts.
- o_A  out  32  ALU operand A.
- o_B  out  32  ALU operand B.
- o_op  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu.
- o_rd  out  5  destination register.
- o_wb_en  out  1  result is written back (rd != 0 and class writes).
- o_pc  out  32  PC of held instruction.
- o_rs2_data  out  32  raw rs2, for stores.
- o_funct3  out  3  instr[14:12], for branch/mem.
- o_cls  out  3  0 alu, 1 load, 2 store, 3 branch, 4 jump, 5 upper.

Behaviour:
- Reset (async, i_rst_n=0):
  - o_valid=0, o_A=0, o_B=0, o_op=0, o_rd=0, o_wb_en=0, o_rs2_data=0, o_funct3=0, o_cls=0, o_pc=RESET_PC_TAG.
  - Applies immediately, including mid-stall; the held instruction is discarded.
- Load condition: load = i_valid & o_ready. On load, all outputs update next edge; latency is 1 cycle from acceptance to o_valid.
- Hold: o_valid & ~i_ready. All outputs hold their values exactly; o_ready=0.
- Drain: if i_ready and no load, o_valid clears to 0 next edge. Data outputs may keep stale values.
- Flush: i_flush=1 sets o_valid to 0 next edge regardless of load or stall. It has priority over load. Data outputs are don't-care.
- Decode by opcode instr[6:0]:
  - 0110011 OP: A=rs1, B=rs2. op from funct3, with funct7[5] selecting sub/sra. cls=alu.
  - 0010011 OP-IMM: A=rs1, B=sign-extended I-imm. funct7[5] only meaningful for srai. cls=alu.
  - 0000011 LOAD: A=rs1, B=I-imm, op=add, cls=load.
  - 0100011 STORE: A=rs1, B=S-imm, op=add, wb_en=0, cls=store.
  - 1100011 BRANCH: A=rs1, B=rs2, wb_en=0, cls=branch. beq/bne give op=sub; blt/bge give slt; bltu/bgeu give sltu.
  - 1101111 JAL and 1100111 JALR: A=pc, B=4, op=add (link value), cls=jump.
  - 0110111 LUI: A=0, B=U-imm, op=add, cls=upper.
  - 0010111 AUIPC: A=pc, B=U-imm, op=add, cls=upper.
  - Any other opcode: treated as a NOP. A=0, B=0, op=add, wb_en=0, cls=alu.
- Shift masking: the ALU shifts by the full B value. For sll/srl/sra (register or immediate form), B={27'b0, src[4:0]}.
- wb_en: 0 whenever rd==0.
- Back-to-back: a load and a drain in the same cycle replace the slot contents with no bubble.

Optional Feature:
- Macro: ID_ILLEGAL_CHK_EN.
- When defined:
  - Adds output o_illegal (1 bit), registered with the slot and reset to 0.
  - o_illegal=1 for unknown opcodes, OP with funct7 not in {0000000, 0100000}, and non-sub/sra funct7[5] misuse. In those cases wb_en is forced to 0.
- When undefined: no port; unknown instructions decode silently as a NOP.

Decomposition:
- Shared package rv32_pkg:
  - ALU op localparams (ALU_ADD..ALU_SLTU, 4 bits).
  - Opcode constants.
  - cls encodings.
- Sub-module imm_gen: combinational; instr in, 32-bit I/S/U immediates out.
- Decode mux and pipeline register stay in id_ex_stage.

Test Plan:
- Reset, then i_instr=32'h002081B3 (add x3,x1,x2), rs1=5, rs2=7, i_valid=1 -> next cycle o_valid=1, o_A=5, o_B=7, o_op=0, o_rd=3, o_wb_en=1.
- 32'h40335293 (srai x5,x6,3), rs1=32'h8000_0000 -> o_op=7, o_B=3, o_rd=5. Separately, sll with rs2=32'h21 -> o_B=1.
- 32'h123450B7 (lui x1,0x12345) -> o_A=0, o_B=32'h1234_5000, o_cls=5. auipc with pc=32'h100 -> o_A=32'h100.
- Hold o_valid=1 with i_ready=0 for 3 cycles while i_instr changes -> outputs stable, o_ready=0. Raise i_ready -> new instruction accepted, no bubble.
- i_flush=1 together with i_valid=1 and o_ready=1 -> o_valid=0 next cycle. Deassert i_rst_n mid-stall -> all outputs reset values immediately.
- beq (32'h00208463) -> o_op=1, o_wb_en=0, o_cls=3. Opcode 7'h7F -> o_wb_en=0; o_illegal=1 when ID_ILLEGAL_CHK_EN is defined.
